// File: rtl/ascon_round_sequencer.sv
// Round controller for the Ascon permutation: issues 12/8/6 rounds per request
// with stall and abort, driving the round index, selector code and round constant.
module ascon_round_sequencer #(
   parameter int CTR_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [1:0]       mode_i,
   input  logic             stall_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             round_en_o,
   output logic [CTR_W-1:0] ctr_o,
   output logic [CTR_W-1:0] rounds_o,
   output logic [7:0]       rc_o,
   output logic             last_o,
   output logic             done_o,
   output logic             err_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [CTR_W-1:0] ctr, ctr_nxt;
   logic [CTR_W-1:0] n, n_nxt;
   logic [CTR_W-1:0] sel, sel_nxt;
   logic [7:0]       rc, rc_nxt;
   logic             last, last_nxt;
   logic             err, err_nxt;
   logic             round_en;

   function automatic logic [CTR_W-1:0] rounds_of(input logic [1:0] mode);
      case (mode)
         2'b00:   rounds_of = CTR_W'(12);
         2'b01:   rounds_of = CTR_W'(8);
         default: rounds_of = CTR_W'(6);
      endcase
   endfunction

   function automatic logic [CTR_W-1:0] sel_of(input logic [1:0] mode);
      case (mode)
         2'b00:   sel_of = CTR_W'(0);
         2'b01:   sel_of = CTR_W'(12);
         default: sel_of = CTR_W'(6);
      endcase
   endfunction

   function automatic logic [7:0] start_rc(input logic [1:0] mode);
      case (mode)
         2'b00:   start_rc = 8'hF0;
         2'b01:   start_rc = 8'hB4;
         default: start_rc = 8'h96;
      endcase
   endfunction

   // Each round lowers the constant by 0x0F, wrapping on 8 bits.
   function automatic logic [7:0] step_rc(input logic [7:0] cur);
      step_rc = cur - 8'h0F;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         ctr   <= '0;
         n     <= '0;
         sel   <= '0;
         rc    <= '0;
         last  <= 1'b0;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         ctr   <= ctr_nxt;
         n     <= n_nxt;
         sel   <= sel_nxt;
         rc    <= rc_nxt;
         last  <= last_nxt;
         err   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ctr_nxt   = ctr;
      n_nxt     = n;
      sel_nxt   = sel;
      rc_nxt    = rc;
      err_nxt   = 1'b0;
      round_en  = 1'b0;
      case (state)
         RUN: begin
            round_en = !stall_i && !abort_i;
            if (abort_i) begin
               state_nxt = IDLE;
               ctr_nxt   = '0;
               sel_nxt   = '0;
               rc_nxt    = '0;
            end else if (round_en) begin
               if (ctr == n) begin
                  state_nxt = DONE;
                  ctr_nxt   = '0;
                  sel_nxt   = '0;
                  rc_nxt    = '0;
               end else begin
                  ctr_nxt = ctr + CTR_W'(1);
                  rc_nxt  = step_rc(rc);
               end
            end
         end
         default: begin
            // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise.
            state_nxt = IDLE;
            ctr_nxt   = '0;
            sel_nxt   = '0;
            rc_nxt    = '0;
            if (start_i) begin
               if (mode_i == 2'b11) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = RUN;
                  ctr_nxt   = CTR_W'(1);
                  n_nxt     = rounds_of(mode_i);
                  sel_nxt   = sel_of(mode_i);
                  rc_nxt    = start_rc(mode_i);
               end
            end
         end
      endcase
      last_nxt = (state_nxt == RUN) && (ctr_nxt == n_nxt);
   end

   assign busy_o     = (state == RUN);
   assign done_o     = (state == DONE);
   assign round_en_o = round_en;
   assign ctr_o      = ctr;
   assign rounds_o   = sel;
   assign rc_o       = rc;
   assign last_o     = last;
   assign err_o      = err;

endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Table-driven bench for ascon_round_sequencer: per-cycle input/expected-output
// rows plus a hand-written reset-mid-run sequence.
module tb_ascon_round_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start_i;
   logic [1:0] mode_i;
   logic       stall_i;
   logic       abort_i;
   logic       busy_o;
   logic       round_en_o;
   logic [4:0] ctr_o;
   logic [4:0] rounds_o;
   logic [7:0] rc_o;
   logic       last_o;
   logic       done_o;
   logic       err_o;

   int checks = 0;
   int errors = 0;

   ascon_round_sequencer #(.CTR_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i),
      .stall_i(stall_i), .abort_i(abort_i), .busy_o(busy_o),
      .round_en_o(round_en_o), .ctr_o(ctr_o), .rounds_o(rounds_o),
      .rc_o(rc_o), .last_o(last_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic [1:0] mode;
      logic       stall;
      logic       abort;
      logic       busy;
      logic       en;
      logic [4:0] ctr;
      logic [4:0] rounds;
      logic [7:0] rc;
      logic       last;
      logic       done;
      logic       err;
   } vec_t;

   vec_t vq[$];

   // Round constants of the 12-round schedule; 8 and 6 rounds use its tail.
   logic [7:0] rc12 [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                             8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

   task automatic add(input logic st, input logic [1:0] md, input logic sl, input logic ab,
                      input logic b, input logic en, input logic [4:0] c, input logic [4:0] r,
                      input logic [7:0] k, input logic l, input logic d, input logic e);
      vec_t v;
      v.start = st; v.mode = md; v.stall = sl; v.abort = ab;
      v.busy = b; v.en = en; v.ctr = c; v.rounds = r; v.rc = k;
      v.last = l; v.done = d; v.err = e;
      vq.push_back(v);
   endtask

   task automatic add_idle();
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input int idx, input logic b, input logic en, input logic [4:0] c,
                          input logic [4:0] r, input logic [7:0] k, input logic l,
                          input logic d, input logic e);
      chk("busy_o", idx, 8'(busy_o), 8'(b));
      chk("round_en_o", idx, 8'(round_en_o), 8'(en));
      chk("ctr_o", idx, 8'(ctr_o), 8'(c));
      chk("rounds_o", idx, 8'(rounds_o), 8'(r));
      chk("rc_o", idx, rc_o, k);
      chk("last_o", idx, 8'(last_o), 8'(l));
      chk("done_o", idx, 8'(done_o), 8'(d));
      chk("err_o", idx, 8'(err_o), 8'(e));
   endtask

   initial begin
      rst_n = 1'b0; start_i = 1'b0; mode_i = 2'b00; stall_i = 1'b0; abort_i = 1'b0;

      // Idle after reset
      add_idle();
      // 12-round run, with an ignored start at ctr 3
      add(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 12; k++)
         add((k == 3), 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 5'(k), 5'd0, rc12[k-1], (k == 12), 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      add_idle();
      // 8-round run
      add(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++)
         add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'(k), 5'd12, rc12[k+3], (k == 8), 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      add_idle();
      // 6-round run, stall for two cycles at ctr 3, then back-to-back start from DONE
      add(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd6, 8'h96, 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 5'd6, 8'h87, 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd6, 8'h78, 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 5'd6, 8'h78, 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd6, 8'h78, 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 5'd6, 8'h69, 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 5'd6, 8'h5A, 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 5'd6, 8'h4B, 1'b1, 1'b0, 1'b0);
      add(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b1, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd1, 5'd6, 8'h96, 1'b0, 1'b0, 1'b0);
      // abort together with stall at ctr 2: abort wins, no done
      add(1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 5'd6, 8'h87, 1'b0, 1'b0, 1'b0);
      add_idle();
      // 12-round run aborted at ctr 5
      add(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      for (int k = 1; k <= 4; k++)
         add(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 5'(k), 5'd0, rc12[k-1], 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 8'hB4, 1'b0, 1'b0, 1'b0);
      add_idle();
      // abort outside RUN is ignored
      add(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      // illegal mode: one err pulse, no run
      add(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      add(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1);
      add_idle();
      add_idle();

      // Reset held for 3 cycles
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all(-1, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < vq.size(); i++) begin
         if (i != 0) @(negedge clk);
         start_i = vq[i].start; mode_i = vq[i].mode;
         stall_i = vq[i].stall; abort_i = vq[i].abort;
         #1;
         chk_all(i, vq[i].busy, vq[i].en, vq[i].ctr, vq[i].rounds, vq[i].rc,
                 vq[i].last, vq[i].done, vq[i].err);
      end

      // Reset mid-run: back to IDLE with no done_o
      @(negedge clk); start_i = 1'b1; mode_i = 2'b01;
      @(negedge clk); start_i = 1'b0; mode_i = 2'b00;
      @(negedge clk); #1;
      chk_all(1000, 1'b1, 1'b1, 5'd2, 5'd12, 8'hA5, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk); #1;
      chk_all(1001, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk_all(1002, 1'b0, 1'b0, 5'd0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ascon_round_sequencer.md
# ascon_round_sequencer

Sequential round controller for the Ascon permutation datapath. It produces the round-counter and round-count selector pair that the round-constant addition stage consumes, plus the matching 8-bit round constant for checking. It runs a start/done handshake with the mode FSM and sits between the AEAD/hash control FSM and the permutation round logic. It issues 12, 8 or 6 rounds per request, with stall and abort support.

## Interface

- CTR_W, 5, width of ctr_o and rounds_o; fixed at 5 for compatibility with the round-constant stage.
- clk  input  1  system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- start_i  input  1  request a permutation run; sampled only in IDLE or DONE.
- mode_i  input  2  round count for the request: 00 = 12 rounds, 01 = 8 rounds, 10 = 6 rounds, 11 = illegal.
- stall_i  input  1  hold the current round (datapath not ready).
- abort_i  input  1  terminate the run immediately.
- busy_o  output  1  high in RUN.
- round_en_o  output  1  high when the datapath must apply the round described by ctr_o/rounds_o/rc_o this cycle.
- ctr_o  output  CTR_W  current round index, 1..N; 0 when not running.
- rounds_o  output  CTR_W  selector code for the round-constant stage: 5'd0 for 12 rounds, 5'd12 for 8 rounds, 5'd6 for 6 rounds; 0 when not running.
- rc_o  output  8  round constant for the current round; 0 when not running.
- last_o  output  1  high while ctr_o == N in RUN.
- done_o  output  1  one-cycle pulse after the final round completes.
- err_o  output  1  one-cycle pulse when a start with mode_i = 11 is rejected.

## Operation

- States: IDLE, RUN, DONE.
- Reset (rst_n = 0 at a clock edge) forces IDLE. All outputs read 0 at reset.
- IDLE/DONE, start_i = 1, legal mode:
  - Latch N (12, 8 or 6) and the selector code.
  - Go to RUN with ctr = 1.
- IDLE/DONE, start_i = 1, mode_i = 11:
  - Stay in or go to IDLE.
  - Pulse err_o next cycle; no run starts.
- DONE with no start goes to IDLE after one cycle.
- RUN:
  - round_en_o = !stall_i && !abort_i.
  - If round_en_o and ctr < N: ctr increments.
  - If round_en_o and ctr == N: go to DONE.
  - If stall_i: hold all state; ctr_o, rc_o and last_o stay stable.
- Abort: abort_i in RUN has priority over stall_i and over completion. Next cycle is IDLE, with no done_o.
- start_i in RUN is ignored. abort_i outside RUN is ignored.
- rc_o = start_const − (ctr−1)·15, computed mod 256 on 8 bits.
  - start_const is 0xF0 for 12 rounds, 0xB4 for 8 rounds, 0x96 for 6 rounds.
  - The final round always yields 0x4B.
- ctr_o never exceeds N and never wraps. rounds_o stays constant for the whole run.

## Timing

- All outputs are registered except round_en_o, which is combinational from state, stall_i and abort_i.
- Start accepted at cycle 0:
  - Cycles 1..N: RUN, with ctr_o = 1..N.
  - Cycle N+1: DONE, done_o = 1, busy_o = 0.
  - Each stalled cycle adds one cycle to this schedule.
- Back-to-back runs: start_i in the DONE cycle enters RUN at N+2 with ctr_o = 1. No idle gap is needed.
- err_o asserts the cycle after the rejected start and lasts exactly one cycle.
- Reset mid-run: IDLE on the next edge; done_o and err_o are not asserted.

## Test plan

- Reset check: hold rst_n low for 3 cycles, then release. Required: every output is 0 and state is IDLE.
- 12-round run: mode 00, start, no stall.
  - rc_o sequence 0xF0, 0xE1, 0xD2, 0xC3, 0xB4, 0xA5, 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B on ctr_o = 1..12.
  - rounds_o = 0; last_o only at ctr 12; done_o at cycle 13.
- 8-round run: mode 01. rounds_o = 12, rc_o runs 0xB4 … 0x4B, done_o at cycle 9.
- 6-round run with stall: mode 10, with stall_i high during ctr = 3 for 2 cycles.
  - ctr_o = 3 and rc_o = 0x78 hold for 3 cycles with round_en_o low for 2 of them.
  - done_o at cycle 9.
- Abort, then illegal start:
  - abort_i at ctr = 5 of a 12-round run gives IDLE next cycle and no done_o.
  - start with mode 11 gives an err_o pulse and busy_o stays 0.
- Back-to-back runs: start_i asserted in the DONE cycle. A second 6-round run begins with ctr_o = 1 and rc_o = 0x96 on the next cycle.
